// File: rtl/mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_arbiter_if
//   Bundle of requester-side handshake and response signals for mul_arbiter.
//
//   req        : per-requester "operation valid" (NREQ bits)
//   a_in/b_in  : operand lanes, lane i at [i*DWIDTH +: DWIDTH]
//   func_in    : 3-bit function code per lane, lane i at [i*3 +: 3]
//   ack        : one-hot (or zero) acceptance, combinational from req
//   resp_valid : one-hot (or zero) owner tag for resp_data
//   resp_data  : registered multiply result
//   busy       : any pipeline stage occupied
//
//   master : requester side (drives req/operands, observes ack/response)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface mul_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 32
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DWIDTH-1:0] a_in;
    logic [NREQ*DWIDTH-1:0] b_in;
    logic [NREQ*3-1:0]      func_in;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        resp_valid;
    logic [DWIDTH-1:0]      resp_data;
    logic                   busy;

    modport master (
        output req, a_in, b_in, func_in,
        input  ack, resp_valid, resp_data, busy
    );

    modport slave (
        input  req, a_in, b_in, func_in,
        output ack, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
//   Shares one fixed-point multiply unit between NREQ requesters. A
//   combinational round-robin arbiter picks one request per cycle; the
//   winner's operands are registered (stage 1), multiplied combinationally,
//   and the result registered (stage 2) with a one-hot owner tag.
//   Latency ack -> resp_valid is 2 cycles, throughput one op per cycle.
//
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-high
//     bus   : mul_arbiter_if.slave (req/a_in/b_in/func_in in,
//             ack/resp_valid/resp_data/busy out)
//
//   Function codes: 000 MUL (low word), 001 MULH (Q3.29, product[60:29]),
//   010 MULHSU (high word, A signed x B unsigned), 011 MULHU (high word,
//   unsigned x unsigned), 100..111 yield 0. Only DWIDTH = 32 is supported.
// ---------------------------------------------------------------------------
module mul_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    mul_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NREQ);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;

    // Multiply unit in fixed-point mode. Operands are extended by one bit
    // with per-function signedness, then widened to 2*DWIDTH; the low
    // 2*DWIDTH bits of that product are exact for every function.
    function automatic logic [DWIDTH-1:0] f_muldiv(
        input logic [2:0]        func,
        input logic [DWIDTH-1:0] a,
        input logic [DWIDTH-1:0] b,
        input logic              en
    );
        logic signed [DWIDTH:0]     ea;
        logic signed [DWIDTH:0]     eb;
        logic signed [2*DWIDTH-1:0] prod;
        logic [DWIDTH-1:0]          res;
        ea   = (func == F_MULHU) ? {1'b0, a} : {a[DWIDTH-1], a};
        eb   = ((func == F_MULHSU) || (func == F_MULHU)) ? {1'b0, b} : {b[DWIDTH-1], b};
        prod = $signed({{(DWIDTH-1){ea[DWIDTH]}}, ea}) *
               $signed({{(DWIDTH-1){eb[DWIDTH]}}, eb});
        case (func)
            F_MUL:             res = prod[DWIDTH-1:0];
            // Q3.29: drop 29 fraction bits, no rounding, no saturation.
            F_MULH:            res = prod[2*DWIDTH-4 -: DWIDTH];
            F_MULHSU, F_MULHU: res = prod[2*DWIDTH-1 -: DWIDTH];
            default:           res = '0;
        endcase
        return en ? res : '0;
    endfunction

    // Control state
    logic [PTR_W-1:0]  r_rr_ptr;
    logic              r_vld_p1;
    logic [PTR_W-1:0]  r_idx_p1;
    logic [NREQ-1:0]   r_vld_p2;

    // Data state
    logic [DWIDTH-1:0] r_a_p1;
    logic [DWIDTH-1:0] r_b_p1;
    logic [2:0]        r_func_p1;
    logic [DWIDTH-1:0] r_data_p2;

    // Arbiter outputs
    logic              w_gnt_any;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic [NREQ-1:0]   w_grant;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [DWIDTH-1:0] w_a_p0;
    logic [DWIDTH-1:0] w_b_p0;
    logic [2:0]        w_func_p0;
    logic [DWIDTH-1:0] w_mul_res;

    // ---- p0: round-robin arbitration and operand select ----
    // Scan starts at r_rr_ptr and wraps; only req and the pointer feed ack,
    // so there is no operand-to-ack path.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gnt_any && bus.req[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = PTR_W'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
        // No acceptance while reset is held.
        if (reset) begin
            w_gnt_any = 1'b0;
        end
        w_grant = w_gnt_any ? (NREQ'(1) << w_gnt_idx) : '0;
    end

    assign w_ptr_nxt = PTR_W'((int'(w_gnt_idx) + 1) % NREQ);
    assign w_a_p0    = bus.a_in[w_gnt_idx*DWIDTH +: DWIDTH];
    assign w_b_p0    = bus.b_in[w_gnt_idx*DWIDTH +: DWIDTH];
    assign w_func_p0 = bus.func_in[w_gnt_idx*3 +: 3];

    // ---- p1: issue register ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_vld_p1  <= 1'b0;
            r_idx_p1  <= '0;
            r_a_p1    <= '0;
            r_b_p1    <= '0;
            r_func_p1 <= '0;
        end else begin
            r_vld_p1 <= w_gnt_any;
            if (w_gnt_any) begin
                r_rr_ptr  <= w_ptr_nxt;
                r_idx_p1  <= w_gnt_idx;
                r_a_p1    <= w_a_p0;
                r_b_p1    <= w_b_p0;
                r_func_p1 <= w_func_p0;
            end
        end
    end

    assign w_mul_res = f_muldiv(r_func_p1, r_a_p1, r_b_p1, r_vld_p1);

    // ---- p2: result register ----
    // resp_data only updates on a valid op; idle cycles keep the old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p2  <= '0;
            r_data_p2 <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1 ? (NREQ'(1) << r_idx_p1) : '0;
            if (r_vld_p1) begin
                r_data_p2 <= w_mul_res;
            end
        end
    end

    assign bus.ack        = w_grant;
    assign bus.resp_valid = r_vld_p2;
    assign bus.resp_data  = r_data_p2;
    assign bus.busy       = r_vld_p1 | (|r_vld_p2);

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Shares one instance of the existing `muldiv` multiply unit between `NREQ` independent requesters, such as equaliser filter taps or a core's execute stage. The unit is used in fixed-point mode. The block arbitrates requests round-robin and registers the winning operands in front of `muldiv`. It registers the product behind `muldiv` and returns it to the winning requester, tagged with a one-hot `resp_valid`. Throughput is one multiply per cycle.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `DWIDTH`, default 32: operand and result width, passed to `muldiv`. Only 32 is supported.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in NREQ: `req[i]` high means requester i has a valid operation on its operand lanes.
- `a_in` in NREQ*DWIDTH: operand A; lane i is `[i*DWIDTH +: DWIDTH]`.
- `b_in` in NREQ*DWIDTH: operand B, same lane layout as `a_in`.
- `func_in` in NREQ*3: `MDFunc` code per lane. 000 = MUL, 001 = MULH (Q3.29 result, product bits 60:29), 010 = MULHSU, 011 = MULHU.
- `ack` out NREQ: one-hot or zero. `ack[i]` high means requester i's operation is accepted this cycle.
- `resp_valid` out NREQ: one-hot or zero. Marks which requester `resp_data` belongs to.
- `resp_data` out DWIDTH: the `muldiv` result, registered.
- `busy` out 1: high when any pipeline stage holds a valid operation.

## Operation
- **Handshake:** a requester raises `req[i]` with stable operands and holds everything until the cycle `ack[i]` is high. A transfer occurs in that cycle. The requester may drop `req[i]` after the transfer or keep it high to issue the next operation; each acked cycle is a new operation. `req` deasserted without an ack is legal, and the request is withdrawn.
- **Arbiter:** combinational round-robin over `req`, using pointer `rr_ptr` (log2 NREQ bits).
  - Search starts at `rr_ptr` and wraps modulo NREQ.
  - The first requester found with its `req` bit set wins, and its `ack` bit goes high.
  - On a grant to index g, `rr_ptr` becomes (g+1) mod NREQ. With no grant, `rr_ptr` holds.
  - There is no backpressure, so a grant is issued every cycle `req` is non-zero.
- **Stage 1 (issue register):** on a grant, captures the winner's A, B, func and index as `s1_idx`, and sets `s1_valid`=1. Otherwise `s1_valid`=0.
- **muldiv connection:** `muldiv` is driven combinationally from the stage-1 registers, with `mulEn` = `s1_valid`. Func codes 100..111 pass through unchanged, so `muldiv` yields 0.
- **Stage 2 (result register):** captures the `muldiv` output into `resp_data` and sets `resp_valid` = (`s1_valid` ? one-hot(`s1_idx`) : 0).
- **`resp_data` when idle:** holds its last value while `resp_valid` is 0. Consumers must ignore `resp_data` in those cycles.
- **`busy`:** equals `s1_valid` OR (`resp_valid` != 0).
- **Arithmetic:** product widths and signedness are exactly as `muldiv` defines. MUL keeps the low 32 bits of the signed product. MULH has no rounding or saturation; bits above 60 are discarded.
- **Same-cycle events:** a requester may be acked in the same cycle it receives `resp_valid` for an earlier operation. Responses always return in grant order.
- **Reset:** asynchronous assertion at any time does the following.
  - `rr_ptr`=0, `s1_valid`=0, all stage-1 operand registers 0.
  - `resp_valid`=0, `resp_data`=0. `busy` is therefore 0.
  - In-flight operations are discarded and never responded to.
  - While `reset` is high, `ack` is forced to 0.

## Timing
- Acceptance is the cycle T in which `ack[i]` is high. Operands are captured at the rising edge ending cycle T.
- `muldiv` evaluates during cycle T+1.
- `resp_valid[i]` and `resp_data` are high and valid for exactly cycle T+2. Latency is 2 cycles from ack to response.
- `ack` is combinational from `req` and `rr_ptr`; there is no combinational path from any operand input to `ack`.
- Sustained throughput is one operation per cycle. Under full load with all `req` high, grants rotate 0,1,...,NREQ-1,0,...
- Reset release: the first grant can occur in the first cycle `reset` is low.

## Test plan
- **Single MUL, requester 2:** `req`=0100, A=7, B=0xFFFFFFFD, func=000. `ack`=0100 in cycle T; two cycles later `resp_valid`=0100 and `resp_data`=0xFFFFFFEB; `busy` falls the cycle after.
- **Fixed-point MULH, requester 0:** A=0x20000000 (1.0), B=0x30000000 (1.5), func=001. `resp_data`=0x30000000 at T+2. Then A=0xE0000000 (-1.0), B=0x30000000 gives 0xD0000000.
- **Round-robin, all four held high for 8 cycles, each lane with distinct operands:** the ack sequence is 0,1,2,3,0,1,2,3. `resp_valid` follows the same sequence delayed by 2 cycles, and each `resp_data` matches its lane's operands. Next, `req`=1010 from `rr_ptr`=0 gives acks 1,3,1,3.
- **MULHU and invalid func:** A=B=0xFFFFFFFF, func=011 gives 0xFFFFFFFE. The next operation with func=101 gives `resp_data`=0 with `resp_valid` still asserted.
- **Back-to-back, requester 1 only:** three consecutive acked cycles with B=1,2,3 and A=5. Responses arrive on consecutive cycles as 5, 10, 15, with no gaps.
- **Reset mid-flight:** grant in cycle T, assert `reset` during T+1. No `resp_valid` is ever produced; all outputs read 0 within the reset cycle; after release, `req`=1111 acks requester 0 first.
